// File: rtl/pipe_regfile_wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_regfile_wb_pkg
//  Description : Shared Y86 definitions for the write-back stage: status
//                codes, instruction codes, register IDs (including RNONE)
//                and an ID range helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_regfile_wb_pkg;

   typedef enum logic [2:0] {
      STAT_AOK = 3'd1,
      STAT_HLT = 3'd2,
      STAT_ADR = 3'd3,
      STAT_INS = 3'd4
   } stat_e;

   typedef enum logic [3:0] {
      ICODE_HALT   = 4'h0,
      ICODE_NOP    = 4'h1,
      ICODE_CMOVXX = 4'h2,
      ICODE_IRMOVQ = 4'h3,
      ICODE_RMMOVQ = 4'h4,
      ICODE_MRMOVQ = 4'h5,
      ICODE_OPQ    = 4'h6,
      ICODE_JXX    = 4'h7,
      ICODE_CALL   = 4'h8,
      ICODE_RET    = 4'h9,
      ICODE_PUSHQ  = 4'hA,
      ICODE_POPQ   = 4'hB
   } icode_e;

   typedef enum logic [3:0] {
      REG_RAX  = 4'h0,
      REG_RCX  = 4'h1,
      REG_RDX  = 4'h2,
      REG_RBX  = 4'h3,
      REG_RSP  = 4'h4,
      REG_RBP  = 4'h5,
      REG_RSI  = 4'h6,
      REG_RDI  = 4'h7,
      REG_R8   = 4'h8,
      REG_R9   = 4'h9,
      REG_R10  = 4'hA,
      REG_R11  = 4'hB,
      REG_R12  = 4'hC,
      REG_R13  = 4'hD,
      REG_R14  = 4'hE,
      REG_NONE = 4'hF
   } reg_id_e;

   // True when the ID names an implemented register. RNONE (15) is never
   // implemented because the register count is capped at 15.
   function automatic logic id_in_range(input logic [3:0] id, input int nregs);
      return int'(id) < nregs;
   endfunction

endpackage
`default_nettype wire

// File: rtl/y86_regarray.sv
`default_nettype none
// ============================================================================
//  Module      : y86_regarray
//  Description : Architectural register array with two write ports (E, M)
//                and three combinational read ports with write-through
//                bypass. Port M wins when both ports target the same ID.
//  Ports       : clk, rst_n          clock, async active-low reset
//                wr_en               write enable for both ports
//                wr_dst_e/wr_val_e   write port E
//                wr_dst_m/wr_val_m   write port M
//                rd_id_a/b/c         read IDs, rd_val_a/b/c read data
//  Revision    : 1.0 - initial release
// ============================================================================
module y86_regarray
   import pipe_regfile_wb_pkg::*;
#(
   parameter int                DATA_W   = 64,
   parameter int                NREGS    = 15,
   parameter logic [DATA_W-1:0] RSP_INIT = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [3:0]        wr_dst_e,
   input  logic [DATA_W-1:0] wr_val_e,
   input  logic [3:0]        wr_dst_m,
   input  logic [DATA_W-1:0] wr_val_m,
   input  logic [3:0]        rd_id_a,
   input  logic [3:0]        rd_id_b,
   input  logic [3:0]        rd_id_c,
   output logic [DATA_W-1:0] rd_val_a,
   output logic [DATA_W-1:0] rd_val_b,
   output logic [DATA_W-1:0] rd_val_c
);

   logic [DATA_W-1:0] regs_q [NREGS];
   logic [DATA_W-1:0] regs_d [NREGS];

   logic [3:0]        rd_id  [3];
   logic [DATA_W-1:0] rd_val [3];

   // Port M is applied last so it overwrites port E on a shared ID.
   always_comb begin
      regs_d = regs_q;
      if (wr_en) begin
         if (id_in_range(wr_dst_e, NREGS)) regs_d[wr_dst_e] = wr_val_e;
         if (id_in_range(wr_dst_m, NREGS)) regs_d[wr_dst_m] = wr_val_m;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= (i == int'(REG_RSP)) ? RSP_INIT : '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   // Bypass priority mirrors the write priority: M before E before array.
   function automatic logic [DATA_W-1:0] read_bypass(
      input logic [3:0]        id,
      input logic [DATA_W-1:0] arr_val
   );
      if (!id_in_range(id, NREGS))      return '0;
      if (wr_en && (id == wr_dst_m))    return wr_val_m;
      if (wr_en && (id == wr_dst_e))    return wr_val_e;
      return arr_val;
   endfunction

   assign rd_id[0] = rd_id_a;
   assign rd_id[1] = rd_id_b;
   assign rd_id[2] = rd_id_c;

   for (genvar p = 0; p < 3; p++) begin : g_rd_port
      assign rd_val[p] = read_bypass(rd_id[p], regs_q[rd_id[p]]);
   end

   assign rd_val_a = rd_val[0];
   assign rd_val_b = rd_val[1];
   assign rd_val_c = rd_val[2];

endmodule
`default_nettype wire

// File: rtl/pipe_regfile_wb.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_regfile_wb
//  Description : Y86 write-back stage. Holds the W pipeline register, writes
//                it into the register array every edge while the machine is
//                running, and tracks a sticky halt once W carries a non-AOK
//                status.
//  Ports       : clk, rst_n                 clock, async active-low reset
//                w_stall, w_bubble          W pipeline control
//                m_stat..m_valM             M-stage results to capture
//                d_srcA/B, d_rvalA/B        decode read ports
//                dbg_sel, dbg_val           debug read port
//                w_stat, w_icode, halted    status outputs
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_regfile_wb
   import pipe_regfile_wb_pkg::*;
#(
   parameter int                DATA_W   = 64,
   parameter int                NREGS    = 15,
   parameter logic [DATA_W-1:0] RSP_INIT = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              w_stall,
   input  logic              w_bubble,
   input  logic [2:0]        m_stat,
   input  logic [3:0]        m_icode,
   input  logic              m_cnd,
   input  logic [3:0]        m_dstE,
   input  logic [3:0]        m_dstM,
   input  logic [DATA_W-1:0] m_valE,
   input  logic [DATA_W-1:0] m_valM,
   input  logic [3:0]        d_srcA,
   input  logic [3:0]        d_srcB,
   output logic [DATA_W-1:0] d_rvalA,
   output logic [DATA_W-1:0] d_rvalB,
   input  logic [3:0]        dbg_sel,
   output logic [DATA_W-1:0] dbg_val,
   output logic [2:0]        w_stat,
   output logic [3:0]        w_icode,
   output logic              halted
);

   logic [2:0]        stat_q,   stat_d;
   logic [3:0]        icode_q,  icode_d;
   logic [3:0]        dste_q,   dste_d;
   logic [3:0]        dstm_q,   dstm_d;
   logic [DATA_W-1:0] vale_q,   vale_d;
   logic [DATA_W-1:0] valm_q,   valm_d;
   logic              halted_q, halted_d;
   logic              wr_en;
   logic              freeze;

   always_comb begin
      stat_d   = stat_q;
      icode_d  = icode_q;
      dste_d   = dste_q;
      dstm_d   = dstm_q;
      vale_d   = vale_q;
      valm_d   = valm_q;
      halted_d = halted_q | (stat_q != STAT_AOK);

      // A non-AOK instruction in W stops the machine: W keeps showing it and
      // nothing further is captured or written until reset.
      freeze = halted_q || (stat_q != STAT_AOK);
      wr_en  = (stat_q == STAT_AOK) && !halted_q;

      if (!freeze) begin
         if (w_bubble) begin
            stat_d  = STAT_AOK;
            icode_d = ICODE_NOP;
            dste_d  = REG_NONE;
            dstm_d  = REG_NONE;
            vale_d  = '0;
            valm_d  = '0;
         end else if (!w_stall) begin
            stat_d  = m_stat;
            icode_d = m_icode;
            // A conditional move whose condition failed must not write.
            dste_d  = ((m_icode == ICODE_CMOVXX) && !m_cnd) ? REG_NONE : m_dstE;
            dstm_d  = m_dstM;
            vale_d  = m_valE;
            valm_d  = m_valM;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_q   <= STAT_AOK;
         icode_q  <= ICODE_NOP;
         dste_q   <= REG_NONE;
         dstm_q   <= REG_NONE;
         vale_q   <= '0;
         valm_q   <= '0;
         halted_q <= 1'b0;
      end else begin
         stat_q   <= stat_d;
         icode_q  <= icode_d;
         dste_q   <= dste_d;
         dstm_q   <= dstm_d;
         vale_q   <= vale_d;
         valm_q   <= valm_d;
         halted_q <= halted_d;
      end
   end

   y86_regarray #(
      .DATA_W   (DATA_W),
      .NREGS    (NREGS),
      .RSP_INIT (RSP_INIT)
   ) u_regarray (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_en),
      .wr_dst_e (dste_q),
      .wr_val_e (vale_q),
      .wr_dst_m (dstm_q),
      .wr_val_m (valm_q),
      .rd_id_a  (d_srcA),
      .rd_id_b  (d_srcB),
      .rd_id_c  (dbg_sel),
      .rd_val_a (d_rvalA),
      .rd_val_b (d_rvalB),
      .rd_val_c (dbg_val)
   );

   assign w_stat  = stat_q;
   assign w_icode = icode_q;
   assign halted  = halted_q;

endmodule
`default_nettype wire

// File: doc/pipe_regfile_wb.md
PIPE_REGFILE_WB -- requirements
Module: pipe_regfile_wb

Interface
REQ-001 Parameter DATA_W, default 64, register/data width in bits.
REQ-002 Parameter NREGS, default 15, number of architectural registers (IDs 0..NREGS-1, NREGS<=15).
REQ-003 Parameter RSP_INIT, default 0, reset value of register 4 (%rsp).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 w_stall  in  1  hold W pipeline register.
REQ-007 w_bubble  in  1  load W with a nop bubble.
REQ-008 m_stat  in  3  M-stage status (AOK=1, HLT=2, ADR=3, INS=4).
REQ-009 m_icode  in  4  M-stage instruction code.
REQ-010 m_cnd  in  1  M-stage condition flag.
REQ-011 m_dstE, m_dstM  in  4 each  destination IDs; 4'hF = RNONE.
REQ-012 m_valE, m_valM  in  DATA_W each  write-back values.
REQ-013 d_srcA, d_srcB  in  4 each  decode read IDs.
REQ-014 d_rvalA, d_rvalB  out  DATA_W each  decode read data.
REQ-015 dbg_sel  in  4; dbg_val  out  DATA_W  debug read port.
REQ-016 w_stat  out  3; w_icode  out  4  current W contents.
REQ-017 halted  out  1  sticky halt indicator.

Function
REQ-018 W register {stat, icode, dstE, dstM, valE, valM} SHALL load from M inputs each edge unless stalled or bubbled.
REQ-019 w_bubble SHALL load W with stat=AOK, icode=1 (nop), dstE=dstM=RNONE, vals=0; w_bubble SHALL override w_stall.
REQ-020 When m_icode==2 (cmovXX) and m_cnd==0, dstE SHALL be captured into W as RNONE.
REQ-021 On each edge, register file SHALL write W.valE to W.dstE and W.valM to W.dstM when W.stat==AOK, halted==0, and ID<NREGS.
REQ-022 If W.dstE==W.dstM (not RNONE), valM SHALL win (popq %rsp semantics).
REQ-023 Register write SHALL occur even during w_stall (W contents written once per edge; stalled W rewrites identical value, harmless).
REQ-024 Reads SHALL be combinational; ID==RNONE or ID>=NREGS returns 0.
REQ-025 Read of an ID equal to W.dstM SHALL return W.valM, else equal to W.dstE SHALL return W.valE (write-through bypass), only when W write is enabled per REQ-021.
REQ-026 dbg_val SHALL follow REQ-024/025 for dbg_sel.
REQ-027 halted SHALL set on the edge where W.stat!=AOK and remain set until reset; W SHALL then freeze (stall forced).
REQ-028 Latency: m_* value visible on d_rval via bypass one edge after capture, in array two edges after capture.

Reset
REQ-029 rst_n low SHALL immediately clear all registers to 0 except reg 4 =RSP_INIT, W to bubble (REQ-019), halted=0.
REQ-030 Reset asserted mid-stall or mid-halt SHALL fully clear state; first capture occurs on first edge after rst_n rises.
REQ-031 After reset d_rvalA/B, dbg_val SHALL read 0 (or RSP_INIT for ID 4), w_stat=1, w_icode=1.

Structure
REQ-032 Stat codes, icode constants, RNONE and register IDs SHALL live in the shared Y86 package/include.
REQ-033 Register array with bypass read ports SHALL be one sub-module, y86_regarray; W register and halt logic in top.

Verification
REQ-034 Reset with RSP_INIT=64'h100: all dbg reads 0 except ID 4 -> 64'h100, w_icode=1.
REQ-035 irmovq: m_icode=3, dstE=1, valE=64'h768bc9eab567cd74 -> after 1 edge d_srcA=1 returns value via bypass; after 2 edges same from array.
REQ-036 popq %rsp: dstE=dstM=4, valE=64'h10, valM=64'h637b8dbc90e27d04 -> reg 4 = valM.
REQ-037 cmovXX m_icode=2, m_cnd=0, dstE=0, valE=64'h758cecbd5b375a85 -> rax unchanged; repeat with m_cnd=1 -> rax updated.
REQ-038 m_stat=HLT with dstE=3 -> no write to reg 3, halted=1 next edge, later AOK writes ignored until rst_n pulse.
REQ-039 w_stall and w_bubble both high -> W=bubble; w_stall alone -> W holds, w_icode unchanged.
